// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshake bundle plus the shared sfifo write port.
// The master modport is the arbiter's view; the slave modport is the requesters/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int unsigned LGNIN = 2,
    parameter int unsigned BW    = 8
);
    localparam int unsigned NIN = 1 << LGNIN;

    logic [NIN-1:0]       i_valid;
    logic [NIN*BW-1:0]    i_data;
    logic [NIN-1:0]       o_ready;
    logic                 o_fifo_wr;
    logic [BW+LGNIN-1:0]  o_fifo_data;
    logic                 i_fifo_full;
    logic [NIN-1:0]       o_grant;
    logic                 o_busy;

    modport master (
        input  i_valid, i_data, i_fifo_full,
        output o_ready, o_fifo_wr, o_fifo_data, o_grant, o_busy
    );

    modport slave (
        output i_valid, i_data, i_fifo_full,
        input  o_ready, o_fifo_wr, o_fifo_data, o_grant, o_busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one sfifo write port among NIN requesters.
// Each word written is tagged {grant index, payload}; nothing is written while the FIFO is full.
// Optional feature macro: FIFOARB_BURST_LOCK_EN keeps a grant for up to 1<<LGBURST words;
// without it every transfer releases the grant and requesters interleave word by word.
module fifo_wr_arbiter #(
    parameter int unsigned LGNIN   = 2,
    parameter int unsigned BW      = 8,
    parameter int unsigned LGBURST = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    fifo_wr_arbiter_if.master bus
);
    localparam int unsigned NIN = 1 << LGNIN;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [LGNIN-1:0]   grant_idx_q, grant_idx_d;
    logic [LGNIN-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NIN-1:0]     grant_q, grant_d;
    logic               busy_q, busy_d;

    logic [LGNIN-1:0]   arb_ptr;
    logic [LGNIN-1:0]   win_idx;
    logic               win_any;
    logic               sel_valid;
    logic [BW-1:0]      sel_data;
    logic               xfer;
    logic               last_beat;
    logic               release_gnt;

`ifdef FIFOARB_BURST_LOCK_EN
    localparam int unsigned MAXBURST = 1 << LGBURST;
    logic [LGBURST-1:0] beat_cnt_q, beat_cnt_d;
`else
    // LGBURST only sizes the beat counter, which exists only when burst locking is built.
    if (LGBURST == 0) begin : g_lgburst_unused
    end
`endif

    // Scan start: rr_ptr when idle, the slot after the current owner when releasing.
    always_comb begin
        arb_ptr = (state_q == GRANT) ? (grant_idx_q + LGNIN'(1)) : rr_ptr_q;
    end

    // First valid requester at or after arb_ptr, wrapping modulo NIN.
    always_comb begin
        logic [LGNIN-1:0] cand;
        win_any = 1'b0;
        win_idx = arb_ptr;
        cand    = arb_ptr;
        for (int unsigned off = NIN; off > 0; off--) begin
            cand = arb_ptr + LGNIN'(off - 1);
            if (bus.i_valid[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Select the owner's valid and payload.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int unsigned k = 0; k < NIN; k++) begin
            if (grant_idx_q == LGNIN'(k)) begin
                sel_valid = bus.i_valid[k];
                sel_data  = bus.i_data[k*BW +: BW];
            end
        end
    end

    // Transfer and release qualification.
    always_comb begin
        xfer        = busy_q && sel_valid && !bus.i_fifo_full;
`ifdef FIFOARB_BURST_LOCK_EN
        last_beat   = (beat_cnt_q == LGBURST'(MAXBURST - 1));
`else
        last_beat   = 1'b1;
`endif
        release_gnt = busy_q && ((xfer && last_beat) || !sel_valid);
    end

    // Next-state: grant from IDLE, release/re-arbitrate from GRANT, count beats.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef FIFOARB_BURST_LOCK_EN
        beat_cnt_d  = beat_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d     = GRANT;
                    grant_idx_d = win_idx;
                    grant_d     = NIN'(1) << win_idx;
                    busy_d      = 1'b1;
`ifdef FIFOARB_BURST_LOCK_EN
                    beat_cnt_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (release_gnt) begin
                    rr_ptr_d = grant_idx_q + LGNIN'(1);
`ifdef FIFOARB_BURST_LOCK_EN
                    beat_cnt_d = '0;
`endif
                    if (win_any) begin
                        grant_idx_d = win_idx;
                        grant_d     = NIN'(1) << win_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                    end
                end else if (xfer) begin
`ifdef FIFOARB_BURST_LOCK_EN
                    beat_cnt_d = beat_cnt_q + LGBURST'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            rr_ptr_q    <= '0;
`ifdef FIFOARB_BURST_LOCK_EN
            beat_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef FIFOARB_BURST_LOCK_EN
            beat_cnt_q  <= beat_cnt_d;
`endif
        end
    end

    assign bus.o_fifo_wr   = xfer;
    assign bus.o_ready     = bus.i_fifo_full ? '0 : grant_q;
    assign bus.o_fifo_data = {grant_idx_q, sel_data};
    assign bus.o_grant     = grant_q;
    assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed stimulus with a write scoreboard for fifo_wr_arbiter.
// Builds with or without FIFOARB_BURST_LOCK_EN; expected orders are chosen to match.
module tb_fifo_wr_arbiter;
    localparam int unsigned LGNIN   = 2;
    localparam int unsigned NIN     = 4;
    localparam int unsigned BW      = 8;
    localparam int unsigned LGBURST = 3;
    localparam int unsigned TW      = BW + LGNIN;

    logic clk;
    logic rst;

    fifo_wr_arbiter_if #(.LGNIN(LGNIN), .BW(BW)) bus ();

    fifo_wr_arbiter #(.LGNIN(LGNIN), .BW(BW), .LGBURST(LGBURST)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [BW-1:0] src_data [NIN][32];
    int            src_len  [NIN];
    int            src_pos  [NIN];
    logic [TW-1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Present the head word of every requester that still has data.
    task automatic drive();
        logic [NIN-1:0]    v;
        logic [NIN*BW-1:0] d;
        v = '0;
        d = '0;
        for (int k = 0; k < NIN; k++) begin
            if (src_pos[k] < src_len[k]) begin
                v[k]          = 1'b1;
                d[k*BW +: BW] = src_data[k][src_pos[k]];
            end
        end
        bus.i_valid = v;
        bus.i_data  = d;
    endtask

    task automatic load(input int k, input int n, input int base);
        for (int i = 0; i < n; i++) src_data[k][i] = BW'(base + i);
        src_len[k] = n;
        src_pos[k] = 0;
    endtask

    task automatic push(input int k, input int w);
        exp_q.push_back({LGNIN'(k), src_data[k][w]});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < NIN; k++) begin
            src_len[k] = 0;
            src_pos[k] = 0;
        end
        drive();
        bus.i_fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (n < 200 && !(exp_q.size() == 0 && bus.i_valid == '0 && bus.o_busy == 1'b0)) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain"}, 32'(n < 200), 32'd1);
        chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Requester model: pop words accepted on the coming edge.
    initial begin
        logic [NIN-1:0] hs;
        forever begin
            @(negedge clk);
            hs = bus.i_valid & bus.o_ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < NIN; k++) if (hs[k]) src_pos[k]++;
            drive();
        end
    end

    // Monitor: every FIFO write must match the next expected word and never hit a full FIFO.
    initial begin
        logic [TW-1:0] e;
        forever begin
            @(negedge clk);
            if (bus.o_fifo_wr === 1'b1) begin
                chk("wr_while_full", 32'(bus.i_fifo_full), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write got=%0h exp=none at %0t", bus.o_fifo_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_data", 32'(bus.o_fifo_data), 32'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NIN-1:0] t4_g [5];
        int             t4_n;
        rst             = 1'b0;
        bus.i_valid     = '0;
        bus.i_data      = '0;
        bus.i_fifo_full = 1'b0;
        for (int k = 0; k < NIN; k++) begin
            src_len[k] = 0;
            src_pos[k] = 0;
        end
        #1 rst = 1'b1;
        #1;
        chk("rst_grant", 32'(bus.o_grant), 32'd0);
        chk("rst_busy",  32'(bus.o_busy), 32'd0);
        chk("rst_wr",    32'(bus.o_fifo_wr), 32'd0);
        chk("rst_ready", 32'(bus.o_ready), 32'd0);

        // Single requester streaming ten words.
        do_reset();
        load(0, 10, 'h11);
        drive();
        for (int i = 0; i < 10; i++) push(0, i);
        @(negedge clk);
        chk("t1_no_comb_grant", 32'(bus.o_grant), 32'd0);
        chk("t1_idle_wr", 32'(bus.o_fifo_wr), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) chk("t1_first_grant", 32'(bus.o_grant), 32'b0001);
            chk("t1_stream", 32'(bus.o_fifo_wr), 32'd1);
        end
        @(negedge clk);
        chk("t1_drop_wr", 32'(bus.o_fifo_wr), 32'd0);
        @(negedge clk);
        chk("t1_idle_busy", 32'(bus.o_busy), 32'd0);
        chk("t1_idle_grant", 32'(bus.o_grant), 32'd0);
        wait_done("t1");

        // All four requesting back to back.
        do_reset();
        load(0, 16, 0);
        load(1, 8, 32);
        load(2, 8, 64);
        load(3, 8, 96);
        drive();
`ifdef FIFOARB_BURST_LOCK_EN
        for (int k = 0; k < NIN; k++) for (int w = 0; w < 8; w++) push(k, w);
`else
        for (int w = 0; w < 8; w++) for (int k = 0; k < NIN; k++) push(k, w);
`endif
        for (int w = 8; w < 16; w++) push(0, w);
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("t2_no_gap", 32'(bus.o_fifo_wr), 32'd1);
        end
        wait_done("t2");

        // FIFO full for five cycles after requester 2's third word.
        do_reset();
        load(2, 8, 'h40);
        drive();
        for (int w = 0; w < 8; w++) push(2, w);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_pre_full_wr", 32'(bus.o_fifo_wr), 32'd1);
        end
        @(posedge clk);
        #1 bus.i_fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_full_wr",    32'(bus.o_fifo_wr), 32'd0);
            chk("t3_full_ready", 32'(bus.o_ready), 32'd0);
            chk("t3_full_grant", 32'(bus.o_grant), 32'b0100);
        end
        @(posedge clk);
        #1 bus.i_fifo_full = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_resume_wr", 32'(bus.o_fifo_wr), 32'd1);
        end
        wait_done("t3");

        // Requester 1 stops after two words while 3 waits.
        do_reset();
        load(1, 2, 'h50);
        load(3, 3, 'h70);
        drive();
`ifdef FIFOARB_BURST_LOCK_EN
        push(1, 0); push(1, 1); push(3, 0); push(3, 1); push(3, 2);
        t4_g[0] = 4'b0010; t4_g[1] = 4'b0010; t4_g[2] = 4'b0010; t4_g[3] = 4'b1000;
        t4_g[4] = 4'b1000;
        t4_n = 4;
`else
        push(1, 0); push(3, 0); push(1, 1); push(3, 1); push(3, 2);
        t4_g[0] = 4'b0010; t4_g[1] = 4'b1000; t4_g[2] = 4'b0010; t4_g[3] = 4'b1000;
        t4_g[4] = 4'b1000;
        t4_n = 5;
`endif
        @(negedge clk);
        for (int i = 0; i < t4_n; i++) begin
            @(negedge clk);
            chk("t4_grant", 32'(bus.o_grant), 32'(t4_g[i]));
`ifdef FIFOARB_BURST_LOCK_EN
            if (i == 2) chk("t4_drop_wr", 32'(bus.o_fifo_wr), 32'd0);
`endif
        end
        wait_done("t4");

        // Asynchronous reset in the middle of a transfer.
        do_reset();
        load(0, 4, 'h80);
        load(2, 2, 'hA0);
        drive();
`ifdef FIFOARB_BURST_LOCK_EN
        push(0, 0); push(0, 1); push(0, 2); push(0, 3); push(2, 0); push(2, 1);
`else
        push(0, 0); push(2, 0); push(0, 1); push(2, 1); push(0, 2); push(0, 3);
`endif
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_grant", 32'(bus.o_grant), 32'd0);
        chk("t5_rst_busy",  32'(bus.o_busy), 32'd0);
        chk("t5_rst_wr",    32'(bus.o_fifo_wr), 32'd0);
        chk("t5_rst_ready", 32'(bus.o_ready), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("t5_post_rst_wr", 32'(bus.o_fifo_wr), 32'd0);
        @(negedge clk);
        chk("t5_restart_grant", 32'(bus.o_grant), 32'b0001);
        wait_done("t5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `sfifo` write port between `NIN` streaming requesters. Each transfer is tagged with its source index so the consumer can demultiplex. The block never writes while the FIFO reports full, so an arbitrated `sfifo` never sets its overflow error. It sits between the per-channel sample/feature producers and the shared sample FIFO ahead of the FFT.

## Interface

Parameters:
- `LGNIN`, 2: log2 of the requester count; `NIN = 1<<LGNIN` (localparam).
- `BW`, 8: payload width per requester.
- `LGBURST`, 3: log2 of the maximum locked burst length; `MAXBURST = 1<<LGBURST`.

Ports:
- `i_clk` input 1: clock; all state on rising edge.
- `i_reset` input 1: reset, asynchronous and active-high.
- `i_valid` input NIN: per-requester data valid.
- `i_data` input NIN*BW: requester k payload in bits `[k*BW +: BW]`.
- `o_ready` output NIN: per-requester accept; at most one bit set.
- `o_fifo_wr` output 1: to `sfifo` `i_wr`.
- `o_fifo_data` output BW+LGNIN: `{grant index, payload}` to `sfifo` `i_data`.
- `i_fifo_full` input 1: from `sfifo` `o_full`.
- `o_grant` output NIN: registered one-hot grant; all zero when idle.
- `o_busy` output 1: registered; high in state GRANT.

## Operation

- States: IDLE (no grant) and GRANT (one requester owns the port).
- Registers: `grant_idx[LGNIN-1:0]`, `o_grant`, `rr_ptr[LGNIN-1:0]` (highest-priority index), `beat_cnt[LGBURST-1:0]`.
- Arbitration: the winner is the first `k` with `i_valid[k]`, scanning `rr_ptr, rr_ptr+1, ...` modulo NIN.
- IDLE -> GRANT when any `i_valid` is set. The winner is loaded into `grant_idx`/`o_grant`, and `beat_cnt` is set to 0.
- Transfer condition: `xfer = o_busy && i_valid[grant_idx] && !i_fifo_full`, computed combinationally.
- `o_fifo_wr = xfer`. `o_ready = o_grant` when `!i_fifo_full`, else 0.
- `o_fifo_data = {grant_idx, i_data[grant_idx*BW +: BW]}`. This value is don't-care when `o_fifo_wr` is low.
- On each `xfer`, `beat_cnt` increments.
- Release from GRANT occurs when:
  - `xfer` occurs with `beat_cnt == MAXBURST-1`, or
  - `!i_valid[grant_idx]` (the requester dropped valid).
- On release:
  - `rr_ptr <= grant_idx+1` (wraps modulo NIN).
  - In the same edge, re-arbitrate with that new pointer. If a winner exists, stay in GRANT with the new `grant_idx` and `beat_cnt=0`; otherwise go to IDLE.
  - The released requester is lowest priority, but it may be re-granted immediately if it is the sole requester.
- Full stall: while `i_fifo_full` is high, the grant is held, `beat_cnt` is frozen, and no release occurs unless valid drops.
- Requesters must hold `i_data` stable while `i_valid && !o_ready`. Dropping valid without a transfer is legal and releases the grant.

## Timing

- Reset (async) sets: state IDLE; `o_grant`, `o_busy`, `o_ready`, `o_fifo_wr` all 0; `rr_ptr=0`; `grant_idx=0`; `beat_cnt=0`.
- Reset asserted mid-burst takes effect immediately. Any in-flight word is not written, and the requester retries after reset.
- Latency: a request into IDLE is granted on the next edge. The first write occurs in the cycle after `i_valid` rises, provided the FIFO is not full.
- Sustained throughput: one word per cycle within a burst. Handover between requesters costs zero idle cycles when another requester is waiting.
- No combinational path from `i_valid` to `o_grant`. Combinational paths `i_fifo_full`/`i_valid` -> `o_fifo_wr` and `i_fifo_full` -> `o_ready` are intentional, because `sfifo` `o_full` is registered.
- FIFO full and a requester's last word coincide: the word is not taken, and release waits until the transfer completes.

## Configuration

- `FIFOARB_BURST_LOCK_EN` defined: burst locking as described, up to MAXBURST words per grant.
- Not defined: every `xfer` releases the grant (equivalent to MAXBURST=1). `LGBURST` is ignored and `beat_cnt` is not built. Requesters interleave word by word.

## Test plan

- Reset, then `i_valid=4'b0001` with data 0x11, 0x12, ... -> grant 0 on the first edge. Writes `{2'd0,8'h11}`, `{2'd0,8'h12}`, ... at one per cycle; with LOCK_EN the grant releases after 8 words and is re-granted to 0.
- All four valid continuously, LOCK_EN, FIFO never full -> bursts of 8 in order 0,1,2,3,0. No idle cycle between bursts; the `o_fifo_data` tag matches the owner.
- Same stimulus without LOCK_EN -> the tag sequence is 0,1,2,3,0,1,... one word each.
- Requester 2 in burst, `i_fifo_full` high for 5 cycles after its 3rd word -> `o_fifo_wr`/`o_ready` are 0 for 5 cycles. The grant holds, and the burst resumes at word 4, totalling 8.
- Requester 1 drops valid after 2 words while 3 is waiting -> grant moves to 3 on the next edge, and `rr_ptr` becomes 2.
- `i_reset` pulsed asynchronously mid-burst -> `o_grant`/`o_busy`/`o_fifo_wr` are 0 immediately. After reset release, arbitration restarts at index 0, and the `sfifo` `o_err` stays low throughout.
